// File: rtl/video_blank_gen.sv
// Video timing recovery from raw HSync/VSync: pixel/line counters, pixel enable, blanking windows,
// line/frame measurement and a horizontal lock flag. Define VIDEO_BLANK_GEN_RUNTIME_EN for
// port-supplied blanking positions that are latched once per frame.
//
// state    | meaning
// UNLOCKED | no usable line-length reference yet (after reset or sync loss)
// TRACK    | counting consecutive lines of equal length
// LOCKED   | horizontal timing stable, locked asserted

module video_blank_gen #(
    parameter int CNT_W      = 11,
    parameter int DIV_LOG2   = 1,
    parameter int HB_START   = 336,
    parameter int HB_END     = 40,
    parameter int VB_START   = 246,
    parameter int VB_END     = 6,
    parameter int LOCK_LINES = 4
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             hs,
    input  logic             vs,
`ifdef VIDEO_BLANK_GEN_RUNTIME_EN
    input  logic [CNT_W-1:0] hb_start_i,
    input  logic [CNT_W-1:0] hb_end_i,
    input  logic [CNT_W-1:0] vb_start_i,
    input  logic [CNT_W-1:0] vb_end_i,
`endif
    output logic             ce_pix,
    output logic             hblank,
    output logic             vblank,
    output logic [CNT_W-1:0] pcnt,
    output logic [CNT_W-1:0] lcnt,
    output logic [CNT_W-1:0] line_len,
    output logic [CNT_W-1:0] frame_lines,
    output logic             locked
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] HB_START_C = CNT_W'(HB_START);
    localparam logic [CNT_W-1:0] HB_END_C   = CNT_W'(HB_END);
    localparam logic [CNT_W-1:0] VB_START_C = CNT_W'(VB_START);
    localparam logic [CNT_W-1:0] VB_END_C   = CNT_W'(VB_END);
    localparam logic [3:0]       LOCK_TGT   = 4'(LOCK_LINES - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_TRACK    = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    logic             old_hs_q, old_vs_q, old_vs_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic [CNT_W-1:0] line_len_q, line_len_d;
    logic [CNT_W-1:0] frame_lines_q, frame_lines_d;
    logic             hblank_q, hblank_d;
    logic             vblank_q, vblank_d;
    state_t           state_q, state_d;
    logic [3:0]       match_q, match_d;

    logic             hs_rise, vs_rise, pcnt_sat, line_match;
    logic [CNT_W-1:0] px;
    logic [CNT_W-1:0] hb_start_v, hb_end_v, vb_start_v, vb_end_v;

    assign hs_rise    = hs & ~old_hs_q;
    // vsync is only meaningful at line granularity, so its edge is judged at hs_rise
    assign vs_rise    = hs_rise & vs & ~old_vs_q;
    assign pcnt_sat   = (pcnt_q == CNT_MAX);
    assign line_match = (pcnt_q == line_len_q);
    assign px         = pcnt_q >> DIV_LOG2;

`ifdef VIDEO_BLANK_GEN_RUNTIME_EN
    logic [CNT_W-1:0] hb_start_q, hb_end_q, vb_start_q, vb_end_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hb_start_q <= HB_START_C;
            hb_end_q   <= HB_END_C;
            vb_start_q <= VB_START_C;
            vb_end_q   <= VB_END_C;
        end else if (vs_rise) begin
            hb_start_q <= hb_start_i;
            hb_end_q   <= hb_end_i;
            vb_start_q <= vb_start_i;
            vb_end_q   <= vb_end_i;
        end
    end

    assign hb_start_v = hb_start_q;
    assign hb_end_v   = hb_end_q;
    assign vb_start_v = vb_start_q;
    assign vb_end_v   = vb_end_q;
`else
    assign hb_start_v = HB_START_C;
    assign hb_end_v   = HB_END_C;
    assign vb_start_v = VB_START_C;
    assign vb_end_v   = VB_END_C;
`endif

    generate
        if (DIV_LOG2 == 0) begin : g_ce_full
            assign ce_pix = 1'b1;
        end else begin : g_ce_div
            assign ce_pix = &pcnt_q[DIV_LOG2-1:0];
        end
    endgenerate

    always_comb begin
        pcnt_d        = pcnt_q;
        lcnt_d        = lcnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        old_vs_d      = old_vs_q;
        if (hs_rise) begin
            pcnt_d     = '0;
            line_len_d = pcnt_q;
            old_vs_d   = vs;
            if (vs_rise) begin
                lcnt_d        = '0;
                frame_lines_d = lcnt_q;
            end else if (lcnt_q != CNT_MAX) begin
                lcnt_d = lcnt_q + 1'b1;
            end
        end else if (!pcnt_sat) begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    // Clear has priority over set when both positions coincide
    always_comb begin
        hblank_d = hblank_q;
        if (px == hb_end_v) begin
            hblank_d = 1'b0;
        end else if (px == hb_start_v) begin
            hblank_d = 1'b1;
        end
        vblank_d = vblank_q;
        if (lcnt_q == vb_end_v) begin
            vblank_d = 1'b0;
        end else if (lcnt_q == vb_start_v) begin
            vblank_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        if (pcnt_sat) begin
            state_d = ST_UNLOCKED;
            match_d = '0;
        end else if (hs_rise) begin
            case (state_q)
                ST_UNLOCKED: begin
                    state_d = ST_TRACK;
                    match_d = '0;
                end
                ST_TRACK: begin
                    if (!line_match) begin
                        match_d = '0;
                    end else if ((match_q + 4'd1) >= LOCK_TGT) begin
                        state_d = ST_LOCKED;
                        match_d = LOCK_TGT;
                    end else begin
                        match_d = match_q + 4'd1;
                    end
                end
                ST_LOCKED: begin
                    if (!line_match) begin
                        state_d = ST_TRACK;
                        match_d = '0;
                    end
                end
                default: begin
                    state_d = ST_UNLOCKED;
                    match_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            old_hs_q      <= 1'b0;
            old_vs_q      <= 1'b0;
            pcnt_q        <= CNT_MAX;
            lcnt_q        <= CNT_MAX;
            line_len_q    <= CNT_MAX;
            frame_lines_q <= CNT_MAX;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            state_q       <= ST_UNLOCKED;
            match_q       <= '0;
        end else begin
            old_hs_q      <= hs;
            old_vs_q      <= old_vs_d;
            pcnt_q        <= pcnt_d;
            lcnt_q        <= lcnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            state_q       <= state_d;
            match_q       <= match_d;
        end
    end

    assign pcnt        = pcnt_q;
    assign lcnt        = lcnt_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign locked      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_video_blank_gen.sv
// Bench for video_blank_gen at default parameters: per-cycle scoreboard against a behavioural
// model, a table of line lengths with expected line_len/locked, and hand-written corner sequences.

module tb_video_blank_gen;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        hs = 1'b0;
    logic        vs = 1'b0;
    logic        ce_pix, hblank, vblank, locked;
    logic [10:0] pcnt, lcnt, line_len, frame_lines;
    logic [10:0] hb_start_r = 11'd336;
    logic [10:0] hb_end_r   = 11'd40;
    logic [10:0] vb_start_r = 11'd246;
    logic [10:0] vb_end_r   = 11'd6;

    video_blank_gen dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .hs          (hs),
        .vs          (vs),
`ifdef VIDEO_BLANK_GEN_RUNTIME_EN
        .hb_start_i  (hb_start_r),
        .hb_end_i    (hb_end_r),
        .vb_start_i  (vb_start_r),
        .vb_end_i    (vb_end_r),
`endif
        .ce_pix      (ce_pix),
        .hblank      (hblank),
        .vblank      (vblank),
        .pcnt        (pcnt),
        .lcnt        (lcnt),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .locked      (locked)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [10:0] pcnt, lcnt, ll, fl;
        logic        hb, vb, lk, ce;
    } exp_t;

    typedef struct {
        int period;
        int exp_ll;
        bit exp_lk;
    } lvec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // behavioural model state
    int m_pcnt, m_lcnt, m_ll, m_fl, m_st, m_match;
    int m_hbs, m_hbe, m_vbs, m_vbe;
    bit m_hb, m_vb, m_ohs, m_ovs;

    // transition trackers
    int hb_rise_at, hb_fall_at, vb_rise_at, vb_fall_at, ce_same;
    bit prev_hb, prev_vb, prev_ce;

    function automatic void model_reset();
        m_pcnt = 2047; m_lcnt = 2047; m_ll = 2047; m_fl = 2047;
        m_hb = 1'b1; m_vb = 1'b1; m_st = 0; m_match = 0; m_ohs = 1'b0; m_ovs = 1'b0;
        m_hbs = 336; m_hbe = 40; m_vbs = 246; m_vbe = 6;
    endfunction

    function automatic void model_step(bit h, bit v);
        bit   rise, vrise, nhb, nvb;
        int   np, nl, nll, nfl, nst, nm, px;
        exp_t e;
        rise  = h && !m_ohs;
        vrise = rise && v && !m_ovs;
        px    = m_pcnt / 2;
        np    = rise ? 0 : ((m_pcnt == 2047) ? 2047 : m_pcnt + 1);
        nll   = rise ? m_pcnt : m_ll;
        nl    = vrise ? 0 : ((rise && m_lcnt != 2047) ? m_lcnt + 1 : m_lcnt);
        nfl   = vrise ? m_lcnt : m_fl;
        nhb   = m_hb;
        if (px == m_hbs) nhb = 1'b1;
        if (px == m_hbe) nhb = 1'b0;
        nvb   = m_vb;
        if (m_lcnt == m_vbs) nvb = 1'b1;
        if (m_lcnt == m_vbe) nvb = 1'b0;
        nst = m_st;
        nm  = m_match;
        if (m_pcnt == 2047) begin
            nst = 0; nm = 0;
        end else if (rise) begin
            if (m_st == 0 || m_pcnt != m_ll) begin
                nst = 1; nm = 0;
            end else if (m_st == 1) begin
                nm = m_match + 1;
                if (nm >= 3) nst = 2;
            end
        end
        e.pcnt = 11'(np); e.lcnt = 11'(nl); e.ll = 11'(nll); e.fl = 11'(nfl);
        e.hb = nhb; e.vb = nvb; e.lk = (nst == 2); e.ce = ((np % 2) == 1);
        sb_q.push_back(e);
        if (vrise) begin
            m_hbs = int'(hb_start_r); m_hbe = int'(hb_end_r);
            m_vbs = int'(vb_start_r); m_vbe = int'(vb_end_r);
        end
        if (rise) m_ovs = v;
        m_ohs = h; m_pcnt = np; m_lcnt = nl; m_ll = nll; m_fl = nfl;
        m_hb = nhb; m_vb = nvb; m_st = nst; m_match = nm;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(bit h, bit v);
        exp_t e;
        hs = h;
        vs = v;
        model_step(h, v);
        @(posedge clk_sys);
        #1;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard: queue empty at %0t", $time);
        end else begin
            e = sb_q.pop_front();
            if ({pcnt, lcnt, line_len, frame_lines, hblank, vblank, locked, ce_pix} !==
                {e.pcnt, e.lcnt, e.ll, e.fl, e.hb, e.vb, e.lk, e.ce}) begin
                n_errors++;
                $display("FAIL cycle@%0t: got pcnt=%0d lcnt=%0d ll=%0d fl=%0d hb=%b vb=%b lk=%b ce=%b expected pcnt=%0d lcnt=%0d ll=%0d fl=%0d hb=%b vb=%b lk=%b ce=%b",
                         $time, pcnt, lcnt, line_len, frame_lines, hblank, vblank, locked, ce_pix,
                         e.pcnt, e.lcnt, e.ll, e.fl, e.hb, e.vb, e.lk, e.ce);
            end
        end
        if (hblank && !prev_hb) hb_rise_at = int'(pcnt);
        if (!hblank && prev_hb) hb_fall_at = int'(pcnt);
        if (vblank && !prev_vb) vb_rise_at = int'(lcnt);
        if (!vblank && prev_vb) vb_fall_at = int'(lcnt);
        if (ce_pix == prev_ce) ce_same++;
        prev_hb = hblank;
        prev_vb = vblank;
        prev_ce = ce_pix;
    endtask

    task automatic line(int period, bit v);
        for (int i = 0; i < period; i++) cyc(i < 4, v);
    endtask

    task automatic clear_trackers();
        hb_rise_at = -1; hb_fall_at = -1; vb_rise_at = -1; vb_fall_at = -1; ce_same = 0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        lvec_t lv[11];
        lv[0]  = '{768, 2047, 1'b0};
        lv[1]  = '{768, 767,  1'b0};
        lv[2]  = '{768, 767,  1'b0};
        lv[3]  = '{768, 767,  1'b0};
        lv[4]  = '{768, 767,  1'b1};
        lv[5]  = '{770, 767,  1'b1};
        lv[6]  = '{768, 769,  1'b0};
        lv[7]  = '{768, 767,  1'b0};
        lv[8]  = '{768, 767,  1'b0};
        lv[9]  = '{768, 767,  1'b0};
        lv[10] = '{768, 767,  1'b1};

        model_reset();
        clear_trackers();
        prev_hb = 1'b1; prev_vb = 1'b1; prev_ce = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_pcnt", pcnt, 2047);
        chk("rst_lcnt", lcnt, 2047);
        chk("rst_line_len", line_len, 2047);
        chk("rst_frame_lines", frame_lines, 2047);
        chk("rst_hblank", hblank, 1);
        chk("rst_vblank", vblank, 1);
        chk("rst_locked", locked, 0);
        reset_n = 1'b1;

        // lock acquisition, one mismatching line, relock; hblank/ce timing on a steady line
        for (int i = 0; i < 11; i++) begin
            if (i == 3) clear_trackers();
            line(lv[i].period, 1'b0);
            chk($sformatf("line%0d_len", i), line_len, lv[i].exp_ll);
            chk($sformatf("line%0d_lock", i), locked, lv[i].exp_lk);
            if (i == 3) begin
                chk("hblank_rise_pcnt", hb_rise_at, 673);
                chk("hblank_fall_pcnt", hb_fall_at, 81);
                chk("ce_pix_toggles", ce_same, 0);
            end
        end

        // sync loss: hs stops, pcnt saturates and lock is dropped
        repeat (2100) cyc(1'b0, 1'b0);
        chk("loss_pcnt", pcnt, 2047);
        chk("loss_locked", locked, 0);
        repeat (10) cyc(1'b0, 1'b0);
        chk("loss_pcnt_hold", pcnt, 2047);
        cyc(1'b1, 1'b0);
        chk("loss_next_hs_pcnt", pcnt, 0);

        // hs held high must not retrigger
        repeat (49) cyc(1'b1, 1'b0);
        chk("hs_held_pcnt", pcnt, 49);
        repeat (700) cyc(1'b0, 1'b0);

        // asynchronous reset mid-line
        cyc(1'b1, 1'b0);
        repeat (400) cyc(1'b0, 1'b0);
        chk("pre_reset_pcnt", pcnt, 400);
        reset_n = 1'b0;
        #1;
        chk("async_rst_pcnt", pcnt, 2047);
        chk("async_rst_hblank", hblank, 1);
        chk("async_rst_vblank", vblank, 1);
        chk("async_rst_locked", locked, 0);
        model_reset();
        sb_q.delete();
        repeat (3) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        cyc(1'b1, 1'b0);
        chk("post_rst_hs_pcnt", pcnt, 0);
        chk("post_rst_hs_lock", locked, 0);
        repeat (3) cyc(1'b1, 1'b0);
        repeat (10) cyc(1'b0, 1'b1);
        chk("vs_no_hs_lcnt", lcnt, 2047);
        chk("vs_no_hs_frame", frame_lines, 2047);
        repeat (754) cyc(1'b0, 1'b0);
        line(768, 1'b0);
        line(768, 1'b0);
        chk("post_rst_no_lock", locked, 0);

        // frames of short lines: vs for 3 lines every 256 lines
        for (int l = 0; l < 256; l++) line(20, l < 3);
        chk("frame_a_lines", frame_lines, 2047);
        clear_trackers();
        for (int l = 0; l < 256; l++) line(20, l < 3);
        chk("frame_b_lines", frame_lines, 255);
        chk("frame_b_lcnt", lcnt, 255);
        chk("vblank_fall_line", vb_fall_at, 6);
        chk("vblank_rise_line", vb_rise_at, 246);

`ifdef VIDEO_BLANK_GEN_RUNTIME_EN
        line(768, 1'b0);
        line(768, 1'b0);
        hb_start_r = 11'd300;
        clear_trackers();
        line(768, 1'b0);
        chk("rt_hb_unchanged", hb_rise_at, 673);
        clear_trackers();
        line(768, 1'b1);
        chk("rt_hb_new_frame", hb_rise_at, 601);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
